// File: rtl/rr_arb_mux.sv
// N-channel valid/ready arbiter (round-robin or forced select) feeding a one-deep output register.
// Latency: 1 cycle from input handshake to out_valid; sustains 1 word/cycle.
// Backpressure: in_ready drops while a held word is stalled by out_ready=0.
module rr_arb_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic                  force_en,
    input  logic [SELW-1:0]       force_sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [SELW:0]    cand;
    logic [SELW:0]    nxt_ptr;
    logic [WIDTH-1:0] sel_dat;
    logic             xfer;

    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (force_en) begin
            // Out-of-range indices (NCH not a power of two) never grant.
            if (({1'b0, force_sel} < NCH_W) && in_valid[force_sel]) begin
                grant_vld = 1'b1;
                grant_idx = force_sel;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                cand = {1'b0, ptr_q} + (SELW+1)'(k);
                if (cand >= NCH_W) cand = cand - NCH_W;
                if (!grant_vld && in_valid[cand[SELW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[SELW-1:0];
                end
            end
        end
    end

    always_comb begin
        sel_dat  = '0;
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == SELW'(i)) begin
                sel_dat     = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load_en && grant_vld && !reset;
            end
        end
    end

    assign xfer = load_en && grant_vld && !reset;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        nxt_ptr     = {1'b0, grant_idx} + (SELW+1)'(1);
        if (nxt_ptr == NCH_W) nxt_ptr = '0;
        if (xfer) begin
            out_data_d  = sel_dat;
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            ptr_d       = nxt_ptr[SELW-1:0];
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel and a 3-channel instance share clock and reset.
module tb_rr_arb_mux;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        force_en;
    logic [1:0]  force_sel;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        force_en3;
    logic [1:0]  force_sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(8), .NCH(4)) u_dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .force_en(force_en), .force_sel(force_sel),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(8), .NCH(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .force_en(force_en3), .force_sel(force_sel3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] ch, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_ch"},    32'(out_ch),    32'(ch));
        chk({tag, "_data"},  32'(out_data),  32'(d));
    endtask

    task automatic chk_out3(input string tag, input logic v, input logic [1:0] ch, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(out_valid3), 32'(v));
        chk({tag, "_ch"},    32'(out_ch3),    32'(ch));
        chk({tag, "_data"},  32'(out_data3),  32'(d));
    endtask

    logic [3:0] rr_rdy [5];
    logic [1:0] rr_ch  [5];
    logic [7:0] rr_dat [5];
    logic [3:0] alt_rdy [3];
    logic [1:0] alt_ch  [3];
    logic [7:0] alt_dat [3];

    initial begin
        rr_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        alt_rdy = '{4'b0010, 4'b1000, 4'b0010};
        alt_ch  = '{2'd1, 2'd3, 2'd1};
        alt_dat = '{8'h22, 8'h44, 8'h22};

        reset      = 1'b1;
        in_data    = 32'h44332211;
        in_valid   = 4'b0000;
        force_en   = 1'b0;
        force_sel  = 2'd0;
        out_ready  = 1'b1;
        in_data3   = 24'h332211;
        in_valid3  = 3'b000;
        force_en3  = 1'b0;
        force_sel3 = 2'd0;
        out_ready3 = 1'b1;

        // reset: in_ready held low even with requests pending
        tick();
        in_valid = 4'b1111;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("rst", 1'b0, 2'd0, 8'h00);

        // round-robin with all channels valid
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr%0d_in_ready", i), 32'(in_ready), 32'(rr_rdy[i]));
            tick();
            chk_out($sformatf("rr%0d", i), 1'b1, rr_ch[i], rr_dat[i]);
        end

        // sparse requests 1010: only ch1/ch3 may see ready (ptr=1 here)
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("alt%0d_in_ready", i), 32'(in_ready), 32'(alt_rdy[i]));
            tick();
            chk_out($sformatf("alt%0d", i), 1'b1, alt_ch[i], alt_dat[i]);
        end

        // stall 3 cycles holding 22; ptr must stay at 2
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'h0);
            tick();
            chk_out($sformatf("stall%0d", i), 1'b1, 2'd1, 8'h22);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("unstall", 1'b1, 2'd2, 8'h33);

        // forced select ch2; ptr becomes 3 after each force transfer
        force_en  = 1'b1;
        force_sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("force%0d_in_ready", i), 32'(in_ready), 32'b0100);
            tick();
            chk_out($sformatf("force%0d", i), 1'b1, 2'd2, 8'h33);
        end
        in_valid = 4'b1011;
        #1;
        chk("force_nogrant_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("force_drain", 1'b0, 2'd2, 8'h33);

        // back to round-robin same cycle: resumes at ptr=3
        force_en = 1'b0;
        #1;
        chk("mode_sw_in_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("mode_sw", 1'b1, 2'd3, 8'h44);

        // NCH=3: one rr transfer, then out-of-range force, then resume
        in_valid3 = 3'b111;
        #1;
        chk("n3_rr0_in_ready", 32'(in_ready3), 32'b001);
        tick();
        chk_out3("n3_rr0", 1'b1, 2'd0, 8'h11);
        force_en3  = 1'b1;
        force_sel3 = 2'd3;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("n3_oor%0d_in_ready", i), 32'(in_ready3), 32'h0);
            tick();
            chk(  $sformatf("n3_oor%0d_valid", i), 32'(out_valid3), 32'h0);
        end
        force_en3 = 1'b0;
        #1;
        chk("n3_res0_in_ready", 32'(in_ready3), 32'b010);
        tick();
        chk_out3("n3_res0", 1'b1, 2'd1, 8'h22);
        #1;
        chk("n3_res1_in_ready", 32'(in_ready3), 32'b100);
        tick();
        chk_out3("n3_res1", 1'b1, 2'd2, 8'h33);
        #1;
        chk("n3_wrap_in_ready", 32'(in_ready3), 32'b001);
        tick();
        chk_out3("n3_wrap", 1'b1, 2'd0, 8'h11);

        // reset mid-transfer: advance ptr to 1 first, then reset
        #1;
        chk("pre_rst_in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("pre_rst", 1'b1, 2'd0, 8'h11);
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("midrst", 1'b0, 2'd0, 8'h00);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("post_rst", 1'b1, 2'd0, 8'h11);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
